// File: rtl/ifu_pkg.sv
// Shared opcode constants and helpers for the instruction fetch unit.
package ifu_pkg;

   localparam logic [3:0] OPC_ADD  = 4'h0;
   localparam logic [3:0] OPC_SUB  = 4'h1;
   localparam logic [3:0] OPC_AND  = 4'h2;
   localparam logic [3:0] OPC_OR   = 4'h3;
   localparam logic [3:0] OPC_MUL  = 4'h4;
   localparam logic [3:0] OPC_DIV  = 4'h5;
   localparam logic [3:0] OPC_HALT = 4'hF;

   function automatic logic [3:0] opcode_of(input logic [7:0] instr);
      return instr[7:4];
   endfunction

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch queue between instruction memory and decoder; flush empties it in one cycle.
module ifu_prefetch_fifo #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         store_q[wr_ptr_q] <= push_data;
      end
   end

   assign valid = (count_q != '0);
   assign head  = store_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction memory, PC and read issue control feeding a prefetch queue.
// Optional even-parity protection of the memory when IFU_PARITY_EN is defined.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned INSTR_W    = 8,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [3:0]  HALT_OPC   = OPC_HALT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               fetch_en,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
`ifdef IFU_PARITY_EN
   output logic               parity_err,
`endif
   output logic               halted
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef IFU_PARITY_EN
   localparam int unsigned MEM_W = INSTR_W + 1;
`else
   localparam int unsigned MEM_W = INSTR_W;
`endif
   localparam int unsigned ENT_W = INSTR_W + ADDR_W;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [MEM_W-1:0]  mem_q [DEPTH];
   logic [MEM_W-1:0]  wr_word;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [MEM_W-1:0]  rd_word_q, rd_word_d;
   logic              inflight_q, inflight_d;
   logic              halted_q, halted_d;
   logic              issue, push, pop, halt_hit;
   logic              fifo_valid;
   logic [ENT_W-1:0]  fifo_head;
   logic [CNT_W-1:0]  fifo_count;

`ifdef IFU_PARITY_EN
   logic parity_err_q, parity_err_d;
   assign wr_word = {^prog_data, prog_data};
`else
   assign wr_word = prog_data;
`endif

   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_q[prog_addr] <= wr_word;
      end
   end

   always_comb begin
      pop = fifo_valid & instr_ready;
      // A pop this cycle frees a slot for the read issued now.
      issue = fetch_en & ~halted_q & ~branch_valid &
              (int'(fifo_count) + int'(inflight_q) < int'(FIFO_DEPTH) + int'(pop));
      push     = inflight_q & ~branch_valid & ~halted_q;
      halt_hit = push & (opcode_of(rd_word_q[INSTR_W-1 -: 8]) == HALT_OPC);

      pc_d       = pc_q;
      rd_addr_d  = rd_addr_q;
      rd_word_d  = rd_word_q;
      inflight_d = issue;
      halted_d   = halted_q;
      if (branch_valid) begin
         pc_d = branch_target;
      end else if (issue) begin
         pc_d = pc_q + 1'b1;
      end
      if (issue) begin
         rd_addr_d = pc_q;
         rd_word_d = mem_q[pc_q];
      end
      if (branch_valid) begin
         halted_d = 1'b0;
      end else if (halt_hit) begin
         halted_d = 1'b1;
      end
`ifdef IFU_PARITY_EN
      parity_err_d = parity_err_q | (push & (^rd_word_q));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         rd_addr_q  <= '0;
         rd_word_q  <= '0;
         inflight_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rd_addr_q  <= rd_addr_d;
         rd_word_q  <= rd_word_d;
         inflight_q <= inflight_d;
         halted_q   <= halted_d;
      end
   end

`ifdef IFU_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`endif

   ifu_prefetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (branch_valid),
      .push      (push),
      .push_data ({rd_addr_q, rd_word_q[INSTR_W-1:0]}),
      .pop       (pop),
      .valid     (fifo_valid),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign instr_valid = fifo_valid;
   assign instr_data  = fifo_valid ? fifo_head[INSTR_W-1:0] : '0;
   assign instr_pc    = fifo_valid ? fifo_head[ENT_W-1:INSTR_W] : '0;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; parity scenario runs when IFU_PARITY_EN is defined.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic       fetch_en;
   logic       branch_valid;
   logic [3:0] branch_target;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr_data;
   logic [3:0] instr_pc;
   logic       halted;
`ifdef IFU_PARITY_EN
   logic       parity_err;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem_m [16];
   logic [11:0] sb [$];

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .prog_we       (prog_we),
      .prog_addr     (prog_addr),
      .prog_data     (prog_data),
      .fetch_en      (fetch_en),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_pc      (instr_pc),
`ifdef IFU_PARITY_EN
      .parity_err    (parity_err),
`endif
      .halted        (halted)
   );

   // Delivery monitor: samples mid-way between input drive (negedge) and the pop edge.
   always begin
      @(negedge clk);
      #3;
      if (rst_n && instr_valid && instr_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL delivery_unexpected got pc=%h data=%h required none", instr_pc,
                     instr_data);
         end else begin
            logic [11:0] exp;
            exp = sb.pop_front();
            if ({instr_pc, instr_data} !== exp) begin
               errors++;
               $display("FAIL delivery got pc=%h data=%h required pc=%h data=%h", instr_pc,
                        instr_data, exp[11:8], exp[7:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(negedge clk);
      prog_we   = 1'b0;
      mem_m[a]  = d;
   endtask

   task automatic branch(input logic [3:0] t);
      branch_valid  = 1'b1;
      branch_target = t;
      @(negedge clk);
      branch_valid  = 1'b0;
   endtask

   task automatic expect_run(input logic [3:0] s, input logic [3:0] e);
      logic [3:0] p;
      p = s;
      forever begin
         sb.push_back({p, mem_m[p]});
         if (p == e) break;
         p = p + 4'd1;
      end
   endtask

   task automatic wait_idle(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (halted && !instr_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({instr_valid, instr_data, instr_pc, halted} !== 14'h0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h pc=%h h=%b required all zero", instr_valid,
                  instr_data, instr_pc, halted);
      end
`ifdef IFU_PARITY_EN
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_parity_err got %b required 0", parity_err);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_fetch got valid=%b required 0", instr_valid);
      end
   endtask

   task automatic test_sequential;
      bit to;
      expect_run(4'h0, 4'h5);
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL seq_latency_cycle1 got valid=%b required 0", instr_valid);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 4'(i) || instr_data !== 8'(i * 16)) begin
            errors++;
            $display("FAIL seq_cycle%0d got v=%b pc=%h d=%h required v=1 pc=%h d=%h", i + 2,
                     instr_valid, instr_pc, instr_data, 4'(i), 8'(i * 16));
         end
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0 || halted !== 1'b1) begin
         errors++;
         $display("FAIL seq_end got timeout=%b left=%0d halted=%b required 0 0 1", to, sb.size(),
                  halted);
      end
   endtask

   task automatic test_backpressure;
      bit to;
      instr_ready = 1'b0;
      expect_run(4'h0, 4'h5);
      branch(4'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (dut.fifo_count > 2) begin
            errors++;
            $display("FAIL bp_occupancy got %0d required <=2", dut.fifo_count);
         end
         if (i >= 1) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 4'h0 || instr_data !== 8'h00) begin
               errors++;
               $display("FAIL bp_head_stable got v=%b pc=%h d=%h required v=1 pc=0 d=00",
                        instr_valid, instr_pc, instr_data);
            end
         end
      end
      instr_ready = 1'b1;
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_release got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

   task automatic test_branch_flush;
      bit to;
      instr_ready = 1'b0;
      branch(4'h0);
      repeat (5) @(negedge clk);
      checks++;
      if (dut.fifo_count !== 2'd2) begin
         errors++;
         $display("FAIL br_full got %0d required 2", dut.fifo_count);
      end
      expect_run(4'hC, 4'h5);
      branch(4'hC);
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL br_flush got valid=%b required 0", instr_valid);
      end
      instr_ready = 1'b1;
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL br_target_run got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

   task automatic test_halt;
      bit to;
      load(4'h3, 8'hF0);
      expect_run(4'h0, 4'h3);
      branch(4'h0);
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_stop got timeout=%b left=%0d halted=%b required 0 0 1", to,
                  sb.size(), halted);
      end
      expect_run(4'h0, 4'h3);
      branch(4'h0);
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_clear got halted=%b required 0", halted);
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL halt_rerun got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

   task automatic test_wrap;
      bit to;
      expect_run(4'hE, 4'h3);
      branch(4'hE);
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL wrap got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

   task automatic test_read_before_write;
      bit to;
      load(4'h8, 8'hF0);
      expect_run(4'h7, 4'h8);
      branch_valid  = 1'b1;
      branch_target = 4'h7;
      @(negedge clk);
      branch_valid  = 1'b0;
      prog_we       = 1'b1;
      prog_addr     = 4'h7;
      prog_data     = 8'h77;
      @(negedge clk);
      prog_we       = 1'b0;
      mem_m[7]      = 8'h77;
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL rbw_old got timeout=%b left=%0d required 0 0", to, sb.size());
      end
      expect_run(4'h7, 4'h8);
      branch(4'h7);
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL rbw_new got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

   task automatic test_reset_midop;
      bit to;
      instr_ready = 1'b0;
      branch(4'h0);
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_valid, instr_data, instr_pc, halted} !== 14'h0) begin
         errors++;
         $display("FAIL midop_reset got v=%b d=%h pc=%h h=%b required all zero", instr_valid,
                  instr_data, instr_pc, halted);
      end
      @(negedge clk);
      expect_run(4'h0, 4'h3);
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
         errors++;
         $display("FAIL midop_restart got timeout=%b left=%0d required 0 0", to, sb.size());
      end
   endtask

`ifdef IFU_PARITY_EN
   task automatic test_parity;
      bit to;
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL par_clean got %b required 0", parity_err);
      end
      dut.mem_q[1][8] = ~dut.mem_q[1][8];
      expect_run(4'h0, 4'h3);
      branch(4'h0);
      repeat (2) @(negedge clk);
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL par_before got %b required 0", parity_err);
      end
      @(negedge clk);
      checks++;
      if (parity_err !== 1'b1) begin
         errors++;
         $display("FAIL par_detect got %b required 1", parity_err);
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0 || parity_err !== 1'b1) begin
         errors++;
         $display("FAIL par_sticky got timeout=%b left=%0d err=%b required 0 0 1", to,
                  sb.size(), parity_err);
      end
   endtask
`endif

   initial begin
      rst_n         = 1'b0;
      prog_we       = 1'b0;
      prog_addr     = '0;
      prog_data     = '0;
      fetch_en      = 1'b0;
      branch_valid  = 1'b0;
      branch_target = '0;
      instr_ready   = 1'b0;
      test_reset();
      for (int a = 0; a < 16; a++) begin
         load(4'(a), (a == 15) ? 8'h0A : {4'(a), 4'h0});
      end
      load(4'h5, 8'hF0);
      test_sequential();
      test_backpressure();
      test_branch_flush();
      test_halt();
      test_wrap();
      test_read_before_write();
      test_reset_midop();
`ifdef IFU_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
